// File: rtl/ninjin_m_axi_dma_if.sv
// AXI4 master bus bundle used by the ninjin DMA engine.
// The master modport is the DMA side; the slave modport is the memory or interconnect side.
interface ninjin_m_axi_dma_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ninjin_m_axi_dma.sv
// Single-burst AXI4 DMA between DDR and a local synchronous-read memory.
// One command at a time: either one read burst into memory or one write burst out of it.
module ninjin_m_axi_dma #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic [ADDR_WIDTH-1:0] ddr_addr,
    input  logic [MEM_AW-1:0]     mem_base,
    input  logic [7:0]            len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    ninjin_m_axi_dma_if.master    axi,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam logic [2:0] BEAT_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        WF   = 3'd4,
        W    = 3'd5,
        B    = 3'd6
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [MEM_AW-1:0]     base_q;
    logic [7:0]            len_q;
    logic [8:0]            cnt;
    logic                  last_beat;
    logic                  beat, fin, bad_resp;
    logic                  arvalid_c, rready_c, awvalid_c, wvalid_c, wlast_c, bready_c, mem_we_c;

    assign last_beat = (cnt[7:0] == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            base_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= fin;
            if (state == IDLE && start) begin
                addr_q <= ddr_addr;
                base_q <= mem_base;
                len_q  <= len;
                cnt    <= '0;
                err    <= 1'b0;
            end else begin
                if (beat)
                    cnt <= cnt + 9'd1;
                if (bad_resp)
                    err <= 1'b1;
            end
        end
    end

    // Every valid/ready output decodes from the registered state alone; only
    // the memory write enable and next state look at the incoming handshakes.
    always_comb begin
        state_nx  = state;
        beat      = 1'b0;
        fin       = 1'b0;
        bad_resp  = 1'b0;
        arvalid_c = 1'b0;
        rready_c  = 1'b0;
        awvalid_c = 1'b0;
        wvalid_c  = 1'b0;
        wlast_c   = 1'b0;
        bready_c  = 1'b0;
        mem_we_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = dir ? AW : AR;
            end
            AR: begin
                arvalid_c = 1'b1;
                if (axi.arready)
                    state_nx = R;
            end
            R: begin
                rready_c = 1'b1;
                if (axi.rvalid) begin
                    mem_we_c = 1'b1;
                    beat     = 1'b1;
                    bad_resp = (axi.rresp != 2'b00);
                    if (last_beat) begin
                        fin      = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            AW: begin
                awvalid_c = 1'b1;
                if (axi.awready)
                    state_nx = WF;
            end
            WF: begin
                state_nx = W;
            end
            W: begin
                wvalid_c = 1'b1;
                wlast_c  = last_beat;
                if (axi.wready) begin
                    beat     = 1'b1;
                    state_nx = last_beat ? B : WF;
                end
            end
            B: begin
                bready_c = 1'b1;
                if (axi.bvalid) begin
                    bad_resp = (axi.bresp != 2'b00);
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = BEAT_SIZE;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_c;
    assign axi.rready  = rready_c;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = BEAT_SIZE;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = awvalid_c;
    assign axi.wdata   = mem_rdata;
    assign axi.wstrb   = '1;
    assign axi.wlast   = wlast_c;
    assign axi.wvalid  = wvalid_c;
    assign axi.bready  = bready_c;

    // The local address wraps naturally in MEM_AW bits; the same address
    // feeds read-beat writes and the write-side prefetch.
    assign mem_we    = mem_we_c;
    assign mem_addr  = base_q + MEM_AW'(cnt);
    assign mem_wdata = axi.rdata;
endmodule
